// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master between NUM_REQ local requesters.
// The winner's command is latched at grant time, exactly one APB transfer is
// requested per grant, and completion is reported with a one-cycle done pulse
// to the owner (plus read data for reads).
// Build option: define APB_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer); otherwise round-robin arbitration is used.
module apb_master_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata,
    output logic                      transfer,
    output logic                      mpwrite,
    output logic [ADDR_W-1:0]         apb_write_paddr,
    output logic [ADDR_W-1:0]         apb_read_paddr,
    output logic [DATA_W-1:0]         apb_write_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] XFER = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

`ifndef APB_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   cand;
`endif

    logic [NUM_REQ-1:0] req_eff;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic               sel_wr;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // Winner search; the owner just completing is masked so it cannot win again immediately.
    always_comb begin
        req_eff   = req & ~done_q;
        win_found = 1'b0;
        win_idx   = '0;
`ifdef APB_ARB_FIXED_PRIO_EN
        // Descending scan so the lowest requesting index is the last (winning) assignment.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_eff[k]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(k);
            end
        end
`else
        cand = '0;
        // Descending scan of rr_ptr+NUM_REQ .. rr_ptr+1 so the nearest candidate after rr_ptr wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_eff[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`endif
    end

    // Select the winner's command from the flattened request buses.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                sel_wr    = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic: grant in IDLE, wait for SETUP in REQ, wait for pready in XFER.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifndef APB_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = REQ;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    wr_d             = sel_wr;
                    addr_d           = sel_addr;
                    wdata_d          = sel_wdata;
`ifndef APB_ARB_FIXED_PRIO_EN
                    owner_d          = win_idx;
`endif
                end
            end
            REQ: begin
                // Master has entered SETUP: drop transfer so only one transfer is issued.
                if (psel && !penable) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (psel && penable && pready) begin
                    done_d  = gnt_q;
                    if (!wr_q) begin
                        rdata_d = prdata;
                    end
`ifndef APB_ARB_FIXED_PRIO_EN
                    rr_ptr_d = owner_q;
`endif
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer without a done pulse.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifndef APB_ARB_FIXED_PRIO_EN
            rr_ptr_q <= PTR_W'(NUM_REQ - 1);
            owner_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifndef APB_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
`endif
        end
    end

    assign transfer        = (state_q == REQ);
    assign busy            = (state_q != IDLE);
    assign mpwrite         = wr_q;
    assign apb_write_paddr = addr_q;
    assign apb_read_paddr  = addr_q;
    assign apb_write_data  = wdata_q;
    assign gnt             = gnt_q;
    assign done            = done_q;
    assign rdata           = rdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: an APB master model answers the arbiter's
// transfer requests, stimulus pushes expected completions into a scoreboard
// and a monitor checks every done pulse against it.
`timescale 1ns/1ps
module tb_apb_master_arbiter;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic             pclk = 1'b0;
    logic             preset = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR-1:0]    req_write = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic             psel, penable, pready;
    logic [DW-1:0]    prdata = '0;
    logic             transfer, mpwrite, busy;
    logic [AW-1:0]    apb_write_paddr, apb_read_paddr;
    logic [DW-1:0]    apb_write_data, rdata;
    logic [NR-1:0]    gnt, done;

    apb_master_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .pclk(pclk), .preset(preset), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .psel(psel), .penable(penable),
        .pready(pready), .prdata(prdata), .transfer(transfer), .mpwrite(mpwrite),
        .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
        .apb_write_data(apb_write_data), .gnt(gnt), .done(done), .rdata(rdata),
        .busy(busy)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // APB master model: IDLE(0) -> SETUP(1) -> ACCESS(2), wait_cfg wait states.
    logic [1:0] m_st;
    int         wcnt;
    int         wait_cfg = 0;
    always @(posedge pclk) begin
        if (preset) begin
            m_st <= 2'd0;
            wcnt <= 0;
        end else begin
            case (m_st)
                2'd0: if (transfer) m_st <= 2'd1;
                2'd1: begin m_st <= 2'd2; wcnt <= wait_cfg; end
                2'd2: if (pready) m_st <= transfer ? 2'd1 : 2'd0;
                      else wcnt <= wcnt - 1;
                default: m_st <= 2'd0;
            endcase
        end
    end
    assign psel    = (m_st != 2'd0);
    assign penable = (m_st == 2'd2);
    assign pready  = (m_st == 2'd2) && (wcnt == 0);

    typedef struct {
        logic [NR-1:0] done;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd;
        int            lat;
        int            gap;
        int            issue;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_rdata = '0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, want, $time);
        end
    endfunction

    // Monitor: samples on the falling edge, pops the scoreboard on each done pulse.
    initial begin : monitor
        exp_t          e;
        int            setups = 0;
        int            last_done = 0;
        logic          cap_wr = 1'b0;
        logic [AW-1:0] cap_addr = '0;
        logic [AW-1:0] cap_raddr = '0;
        logic [DW-1:0] cap_wdata = '0;
        forever begin
            @(negedge pclk);
            if (preset) begin
                setups    = 0;
                exp_rdata = '0;
            end else begin
                if (penable) chk("transfer_low_in_access", transfer, 0);
                if (psel && !penable) begin
                    setups++;
                    cap_wr    = mpwrite;
                    cap_addr  = apb_write_paddr;
                    cap_raddr = apb_read_paddr;
                    cap_wdata = apb_write_data;
                end
                if (busy && sb.size() != 0) chk("gnt_owner", gnt, sb[0].done);
                if (done != '0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", done, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_vec", done, e.done);
                        chk("gnt_cleared_on_done", gnt, 0);
                        chk("setups_per_grant", setups, 1);
                        chk("pwrite", cap_wr, e.wr);
                        chk("write_paddr", cap_addr, e.addr);
                        chk("read_paddr", cap_raddr, e.addr);
                        if (e.wr) chk("pwdata", cap_wdata, e.wdata);
                        else exp_rdata = e.rd;
                        chk("rdata", rdata, exp_rdata);
                        if (e.lat >= 0) chk("latency", cyc - e.issue, e.lat);
                        if (e.gap >= 0) chk("done_gap", cyc - last_done, e.gap);
                    end
                    setups    = 0;
                    last_done = cyc;
                end
            end
        end
    end

    task automatic step();
        @(negedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push(input int idx, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                        input int lat, input int gap);
        exp_t e;
        e.done      = '0;
        e.done[idx] = 1'b1;
        e.wr        = wr;
        e.addr      = a;
        e.wdata     = wd;
        e.rd        = rd;
        e.lat       = lat;
        e.gap       = gap;
        e.issue     = cyc;
        sb.push_back(e);
    endtask

    task automatic set_req(input int idx, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req_write[idx]          = wr;
        req_addr[idx*AW +: AW]  = a;
        req_wdata[idx*DW +: DW] = wd;
        req[idx]                = 1'b1;
    endtask

    task automatic wait_dones(input int n, input int budget);
        int got = 0;
        int t = 0;
        while (got < n && t < budget) begin
            step();
            t++;
            if (done != '0) got++;
        end
        chk("done_count_within_budget", got, n);
    endtask

    task automatic check_zero();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_transfer", transfer, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mpwrite", mpwrite, 0);
        chk("rst_write_paddr", apb_write_paddr, 0);
        chk("rst_read_paddr", apb_read_paddr, 0);
        chk("rst_write_data", apb_write_data, 0);
    endtask

    initial begin : stimulus
        int t;
        int first_i;
        int second_i;
        int idx;

        preset = 1'b1;
        idle(3);
        check_zero();
        preset = 1'b0;
        step();

        // Round-robin with requesters 0, 1 and 3 held: order 0,1,3,0,1,3, 4 cycles apart.
        prdata   = 8'h3C;
        wait_cfg = 0;
        for (int r = 0; r < 2; r++) begin
            push(0, 1'b1, 8'h10, 8'hA0, 8'h00, (r == 0) ? 4 : -1, (r == 0) ? -1 : 4);
            push(1, 1'b1, 8'h11, 8'hA1, 8'h00, -1, 4);
            push(3, 1'b0, 8'h13, 8'h00, 8'h3C, -1, 4);
        end
        set_req(0, 1'b1, 8'h10, 8'hA0);
        set_req(1, 1'b1, 8'h11, 8'hA1);
        set_req(3, 1'b0, 8'h13, 8'h00);
        wait_dones(6, 80);
        req = '0;
        idle(2);

        // Zero-wait write from requester 0.
        push(0, 1'b1, 8'h12, 8'h34, 8'h00, 4, -1);
        set_req(0, 1'b1, 8'h12, 8'h34);
        wait_dones(1, 20);
        req[0] = 1'b0;
        idle(2);

        // Read from requester 2 with three wait states.
        prdata   = 8'hA5;
        wait_cfg = 3;
        push(2, 1'b0, 8'h40, 8'h00, 8'hA5, 7, -1);
        set_req(2, 1'b0, 8'h40, 8'h00);
        wait_dones(1, 30);
        req[2]   = 1'b0;
        wait_cfg = 0;
        idle(2);

        // Command latching: requester inputs change after grant.
        push(1, 1'b1, 8'h0F, 8'h55, 8'h00, 4, -1);
        set_req(1, 1'b1, 8'h0F, 8'h55);
        t = 0;
        while (!gnt[1] && t < 5) begin
            step();
            t++;
        end
        chk("gnt1_granted", gnt[1], 1);
        req_wdata[1*DW +: DW] = 8'hFF;
        req_addr[1*AW +: AW]  = 8'hEE;
        wait_dones(1, 20);
        req[1] = 1'b0;
        idle(2);

        // Requesters 3 and 1 held together.
`ifdef APB_ARB_FIXED_PRIO_EN
        first_i  = 1;
        second_i = 3;
`else
        first_i  = 3;
        second_i = 1;
`endif
        for (int k = 0; k < 4; k++) begin
            idx = (k % 2 == 0) ? first_i : second_i;
            push(idx, 1'b1, 8'(8'h30 + idx), 8'(8'hC0 + idx), 8'h00,
                 (k == 0) ? 4 : -1, (k == 0) ? -1 : 4);
        end
        set_req(3, 1'b1, 8'h33, 8'hC3);
        set_req(1, 1'b1, 8'h31, 8'hC1);
        wait_dones(4, 60);
        req = '0;
        idle(2);

        // Reset in the middle of a wait-stated read: abort without done.
        wait_cfg = 10;
        set_req(2, 1'b0, 8'h77, 8'h00);
        t = 0;
        while (!penable && t < 10) begin
            step();
            t++;
        end
        chk("reached_access", penable, 1);
        step();
        chk("pready_low_before_reset", pready, 0);
        preset = 1'b1;
        req    = '0;
        step();
        check_zero();
        preset   = 1'b0;
        wait_cfg = 0;
        idle(3);
        chk("idle_after_reset", busy, 0);

        // Normal transaction after reset.
        push(0, 1'b1, 8'h5A, 8'h6B, 8'h00, 4, -1);
        set_req(0, 1'b1, 8'h5A, 8'h6B);
        wait_dones(1, 20);
        req[0] = 1'b0;
        idle(3);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
